// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with generic width/depth, programmable
//   almost-full/almost-empty thresholds, an occupancy count, sticky
//   overflow/underflow flags and an optional first-word-fall-through read port.
// Latency: write->visible 1 cycle; FWFT=0 read data 1 cycle after r_en;
//   FWFT=1 head word presented combinationally from the storage array.
// Backpressure: writes while full and reads while empty are dropped and
//   recorded in the sticky overflow/underflow flags; no pass-through when full.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   w_en, data_in       write request and data
//   r_en                read request (FWFT=1: pop the head word)
//   clr_err             synchronous clear of overflow/underflow
//   data_out            read data (FWFT=1: head word, forced to 0 while empty)
//   full, empty         count == DEPTH, count == 0
//   almost_full/_empty  count >= AF_THRESH, count <= AE_THRESH
//   fifo_cnt            occupancy 0..DEPTH
//   overflow/underflow  sticky error flags

module fifo_sync_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_en,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      r_en,
  input  logic                      clr_err,
  output logic [DATA_W-1:0]         data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    fifo_cnt,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Storage: deliberately not reset; the pointers define what is valid.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          full_q,   full_d;
  logic          empty_q,  empty_d;
  logic          af_q,     af_d;
  logic          ae_q,     ae_d;
  logic          ovf_q,    ovf_d;
  logic          udf_q,    udf_d;

  logic          wr_ok;
  logic          rd_ok;

  // ---------------------------------------------------------------------------
  // Next-state logic. Accept decisions use the registered flags, i.e. the state
  // before the edge. Flags are then derived from the next count so they are
  // already correct in the cycle right after the causing edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ok    = w_en & ~full_q;
    rd_ok    = r_en & ~empty_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    // DEPTH is a power of two, so natural AW-bit overflow is the wrap.
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Pointers carry no wrap bit; full/empty come only from the count.
    full_d  = (cnt_d == DEPTH_C);
    empty_d = (cnt_d == '0);
    af_d    = (cnt_d >= AF_C);
    ae_d    = (cnt_d <= AE_C);

    // Clear first, then a new error in the same cycle re-sets the flag.
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (w_en & full_q)  ovf_d = 1'b1;
    if (r_en & empty_q) udf_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage write. Suppressed while reset is held so nothing lands in the
  // array that the (held-at-zero) pointers would later expose.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; forced to zero while empty so the port
      // is deterministic out of reset rather than showing stale storage.
      assign data_out = empty_q ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;

      // Registered read: loads only on an accepted read, holds otherwise.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
        end else if (rd_ok) begin
          dout_q <= mem_q[rd_ptr_q];
        end
      end

      assign data_out = dout_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign fifo_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: drives one stimulus stream into a standard-read and an
//   FWFT instance (DEPTH=16, DATA_W=8) and compares both against a queue model.
// Covers fill/overflow, drain/underflow, wrap, simultaneous access, reset, random.

module tb_fifo_sync_param;

  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en, r_en, clr_err;
  logic [7:0] data_in;

  logic [7:0] d0, d1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] cnt0, cnt1;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .clr_err(clr_err),
    .data_out(d0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .fifo_cnt(cnt0), .overflow(ovf0), .underflow(udf0)
  );

  fifo_sync_param #(.DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .clr_err(clr_err),
    .data_out(d1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .fifo_cnt(cnt1), .overflow(ovf1), .underflow(udf1)
  );

  // Reference model
  logic [7:0] mq[$];
  logic [7:0] exp_dout;
  logic       exp_ovf, exp_udf;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    check("cnt",       32'(cnt0),   32'(sz));
    check("cnt_fwft",  32'(cnt1),   32'(sz));
    check("full",      32'(full0),  32'(sz == DEPTH));
    check("empty",     32'(empty0), 32'(sz == 0));
    check("afull",     32'(af0),    32'(sz >= AF));
    check("aempty",    32'(ae0),    32'(sz <= AE));
    check("ovf",       32'(ovf0),   32'(exp_ovf));
    check("udf",       32'(udf0),   32'(exp_udf));
    check("empty_fw",  32'(empty1), 32'(sz == 0));
    check("full_fw",   32'(full1),  32'(sz == DEPTH));
    check("ovf_fw",    32'(ovf1),   32'(exp_ovf));
    check("udf_fw",    32'(udf1),   32'(exp_udf));
    check("dout",      32'(d0),     32'(exp_dout));
    if (sz > 0) check("dout_fw", 32'(d1), 32'(mq[0]));
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    int  sz;
    logic was_full, was_empty;
    w_en = w; data_in = d; r_en = r; clr_err = c;
    @(posedge clk);
    sz        = mq.size();
    was_full  = (sz == DEPTH);
    was_empty = (sz == 0);
    if (r && !was_empty) exp_dout = mq.pop_front();
    if (w && !was_full)  mq.push_back(d);
    if (c) begin
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end
    if (w && was_full)  exp_ovf = 1'b1;
    if (r && was_empty) exp_udf = 1'b1;
    #1;
    check_all();
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
  endtask

  // Reset asserted asynchronously in the middle of a cycle.
  task automatic do_reset();
    w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = '0;
    #2 rst = 1'b1;
    #1;
    mq.delete();
    exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    check("rst_cnt",   32'(cnt0),   32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_full",  32'(full0),  32'd0);
    check("rst_ae",    32'(ae0),    32'd1);
    check("rst_af",    32'(af0),    32'd0);
    check("rst_dout",  32'(d0),     32'd0);
    check("rst_ovf",   32'(ovf0),   32'd0);
    check("rst_cnt_fw",32'(cnt1),   32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] nd;
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; data_in = '0;
    exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    @(negedge clk);
    do_reset();

    // 1: fill to full, then a dropped write
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);

    // 2: drain in order, then one read too many
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // 3: half full, sustained simultaneous access across pointer wrap
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    nd = 8'h20;
    for (int i = 0; i < 8; i++) begin cycle(1'b1, nd, 1'b0, 1'b0); nd++; end
    for (int i = 0; i < 20; i++) begin cycle(1'b1, nd, 1'b1, 1'b0); nd++; end

    // 4: simultaneous access on an empty FIFO
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // 5: fall-through of a word written into an empty FIFO
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // 6: reset with data inside, then first word after release
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // clr_err alone clears; clr_err with a new overflow keeps it set
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic, alternating write-heavy and read-heavy phases
    for (int i = 0; i < 2000; i++) begin
      logic w, r, c;
      int   wp;
      wp = ((i / 150) % 2 == 0) ? 75 : 25;
      w  = ($urandom_range(99) < wp);
      r  = ($urandom_range(99) < (100 - wp));
      c  = ($urandom_range(15) == 0);
      if ($urandom_range(399) == 0) do_reset();
      else cycle(w, 8'($urandom), r, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the fixed-size 8-bit FIFO_4096 block.
- Adds generic width and depth, programmable almost-full/almost-empty thresholds, and a full occupancy count.
- Adds sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode.
- Used as the buffering primitive between datapath stages; it can be cascaded to build deeper buffers.

Parameters:
- DATA_W, 8: data word width in bits (1..64).
- DEPTH, 16: number of entries; power of two, 4..4096.
- AF_THRESH, 14: almost_full asserts when count >= AF_THRESH (1..DEPTH-1).
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH (0..DEPTH-2).
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- w_en  in  1  write request
- data_in  in  DATA_W  write data
- r_en  in  1  read request (FWFT: pop the head word)
- clr_err  in  1  synchronous clear of overflow and underflow
- data_out  out  DATA_W  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- fifo_cnt  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (async assert, sync release):
  - Pointers = 0, fifo_cnt = 0, data_out = 0, overflow = underflow = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
- All flags and fifo_cnt are registered and derived from the count, so they update in the same cycle as the causing clock edge.
- Accept rules use the flags as they were before the clock edge:
  - wr_ok = w_en & ~full.
  - rd_ok = r_en & ~empty.
- Write: on wr_ok, mem[wr_ptr] <= data_in and wr_ptr increments, wrapping modulo DEPTH.
- Read, FWFT=0:
  - On rd_ok, data_out <= mem[rd_ptr] and rd_ptr increments; 1-cycle latency.
  - data_out holds its value when no read is accepted.
- Read, FWFT=1:
  - data_out continuously reflects mem[rd_ptr] whenever empty=0; it is invalid (don't-care) when empty=1.
  - On rd_ok, rd_ptr advances and the next word appears after the edge.
  - A word written into an empty FIFO is visible on data_out the cycle after the write edge, when empty deasserts.
- Count update: +1 on wr_ok & ~rd_ok; -1 on rd_ok & ~wr_ok; unchanged otherwise.
- Simultaneous r_en & w_en:
  - Not full and not empty: both accepted, count unchanged.
  - Empty: write accepted, read rejected, underflow set.
  - Full: read accepted, write rejected, overflow set. There is no pass-through.
- Error flags:
  - overflow <= 1 on w_en & full; underflow <= 1 on r_en & empty.
  - clr_err clears both; a new error in the same cycle wins over the clear.
- Wrap-around: pointers carry no extra bit; full/empty come from fifo_cnt only, so they are unambiguous at wrap.
- Reset mid-operation: all contents are abandoned immediately. The first read after release returns the first word written after release.

Test Plan:
1. Reset, then 16 writes 0x01..0x10 (DEPTH=16) -> full=1 after the 16th edge, fifo_cnt=16, almost_full from the 14th write; 17th write 0xAA dropped, overflow=1.
2. Read 16 words in FWFT=0 -> data_out 0x01..0x10 in order, each 1 cycle after r_en; empty=1 after the last; one extra r_en -> underflow=1, data_out holds 0x10.
3. Fill 8, then 20 cycles of simultaneous w_en/r_en with incrementing data -> fifo_cnt stays 8, output order is preserved across pointer wrap, no error flags.
4. Empty FIFO, w_en & r_en together with 0x55 -> write accepted, fifo_cnt=1, underflow=1; next cycle a read returns 0x55.
5. FWFT=1: write 0x3C into empty -> empty=0 and data_out=0x3C the next cycle without r_en; r_en pops it, empty=1.
6. Fill 5, assert rst mid-cycle -> immediately fifo_cnt=0, empty=1, data_out=0; write 0x77 then read -> 0x77. Also: clr_err clears sticky flags, but is overridden by a simultaneous overflow.
